ks_sum_pipe: RTL and testbench

// - Consumer end of the 16-bit Kogge-Stone prefix network. Takes the final group-generate vector and the bitwise propagates, and forms the sum, carry-out and flags.
// - Two-stage registered pipeline with a valid/ready handshake on both sides.
// - Sits between the last prefix array and the datapath writeback.

---
 rtl/ks_pkg.sv | 17 +
 rtl/ks_sum_xor.sv | 17 +
 rtl/ks_sum_pipe.sv | 107 ++++++++++
 tb/tb_ks_sum_pipe.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ks_pkg.sv
// Shared types and sizes for the Kogge-Stone sum pipeline.
// Optional flag outputs are enabled by KS_FLAGS_EN in ks_sum_pipe.
package ks_pkg;

    localparam int KS_WIDTH = 16;
    localparam int KS_CNT_W = 16;

    typedef logic [KS_WIDTH-1:0] ks_vec_t;

    typedef struct packed {
        logic    valid;
        ks_vec_t p;
        ks_vec_t g;
        logic    cin;
    } ks_stage_t;

endpackage

// File: rtl/ks_sum_xor.sv
// Final sum stage of the prefix adder: propagate xor incoming carry.
// Purely combinational, shared with the non-pipelined adder.
module ks_sum_xor #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] g,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Carry into bit i is the group generate of bit i-1 (cin for bit 0).
    assign sum  = p ^ {g[WIDTH-2:0], cin};
    assign cout = g[WIDTH-1];

endmodule

// File: rtl/ks_sum_pipe.sv
// Two-stage registered sum/flags pipeline with valid/ready on both sides.
// Define KS_FLAGS_EN to build the zero/overflow flag registers.
module ks_sum_pipe
    import ks_pkg::*;
#(
    parameter int WIDTH = KS_WIDTH,
    parameter int CNT_W = KS_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_Pk,
    input  logic [WIDTH-1:0] in_Gk,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_zero,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_count
);

    ks_stage_t        s1_q;
    ks_stage_t        s1_d;
    logic             s2_valid;
    logic             s2_valid_d;
    logic             s1_adv;
    logic             s2_adv;
    logic             s1_load;
    logic             s2_load;
    logic             out_fire;
    logic [WIDTH-1:0] s1_sum;
    logic             s1_cout;

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_q.valid || s2_adv;
    assign in_ready  = s1_adv;
    assign s1_load   = in_valid && s1_adv;
    assign s2_load   = s1_q.valid && s2_adv;
    assign out_valid = s2_valid;
    assign out_fire  = s2_valid && out_ready;

    ks_sum_xor #(
        .WIDTH(WIDTH)
    ) u_sum (
        .p   (s1_q.p),
        .g   (s1_q.g),
        .cin (s1_q.cin),
        .sum (s1_sum),
        .cout(s1_cout)
    );

    // A load always wins over a drain, so a full stage shifts in place.
    always_comb begin
        s1_d       = s1_q;
        s2_valid_d = s2_valid;
        if (s1_load) begin
            s1_d = '{valid: 1'b1, p: in_Pk, g: in_Gk, cin: in_cin};
        end else if (s2_load) begin
            s1_d.valid = 1'b0;
        end
        if (s2_load) begin
            s2_valid_d = 1'b1;
        end else if (out_fire) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= '0;
            s2_valid  <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_count <= '0;
        end else begin
            s1_q     <= s1_d;
            s2_valid <= s2_valid_d;
            if (s2_load) begin
                out_sum  <= s1_sum;
                out_cout <= s1_cout;
            end
            if (out_fire) begin
                out_count <= out_count + CNT_W'(1);
            end
        end
    end

`ifdef KS_FLAGS_EN
    // Overflow: carry into the MSB differs from the carry out of it.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_zero <= 1'b0;
            out_ovf  <= 1'b0;
        end else if (s2_load) begin
            out_zero <= (s1_sum == '0);
            out_ovf  <= s1_q.g[WIDTH-1] ^ s1_q.g[WIDTH-2];
        end
    end
`else
    assign out_zero = 1'b0;
    assign out_ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_ks_sum_pipe.sv
// Randomized and directed bench for ks_sum_pipe against an a+b+cin model.
// Expects flags only when built with KS_FLAGS_EN.
module tb_ks_sum_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_Pk;
    logic [15:0] in_Gk;
    logic        in_cin;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_sum;
    logic        out_cout;
    logic        out_zero;
    logic        out_ovf;
    logic [15:0] out_count;

    logic [15:0] ta = '0;
    logic [15:0] tb_b = '0;
    logic        tcin = 1'b0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        int          t;
    } ent_t;

    ent_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ncyc = 0;
    int   exp_cnt = 0;

    always #5 clk = ~clk;

    ks_sum_pipe dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_Pk    (in_Pk),
        .in_Gk    (in_Gk),
        .in_cin   (in_cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_cout (out_cout),
        .out_zero (out_zero),
        .out_ovf  (out_ovf),
        .out_count(out_count)
    );

    // Upstream prefix network stand-in: ripple carries from a, b, cin.
    always_comb begin
        logic c;
        c      = tcin;
        in_cin = tcin;
        in_Pk  = ta ^ tb_b;
        in_Gk  = '0;
        for (int i = 0; i < 16; i++) begin
            in_Gk[i] = (ta[i] & tb_b[i]) | ((ta[i] ^ tb_b[i]) & c);
            c        = in_Gk[i];
        end
    end

    // Returns {ovf, zero, cout, sum[15:0]}.
    function automatic logic [18:0] model(logic [15:0] a, logic [15:0] b,
                                          logic cin);
        logic [16:0] s;
        logic        z;
        logic        v;
        s = {1'b0, a} + {1'b0, b} + {16'd0, cin};
        z = (s[15:0] == 16'd0);
        v = (a[15] == b[15]) && (s[15] != a[15]);
        return {v, z, s[16], s[15:0]};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp,
                     $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            exp_cnt = 0;
        end else begin
            logic        exp_ov;
            logic [18:0] m;
            ncyc++;
            exp_ov = (q.size() > 0) && (ncyc >= q[0].t + 2);
            chk("out_valid", 32'(out_valid), 32'(exp_ov));
            chk("in_ready", 32'(in_ready),
                32'(!(q.size() >= 2 && !out_ready)));
            chk("out_count", 32'(out_count), 32'(exp_cnt[15:0]));
            if (out_valid && exp_ov) begin
                m = model(q[0].a, q[0].b, q[0].cin);
                chk("out_sum", 32'(out_sum), 32'(m[15:0]));
                chk("out_cout", 32'(out_cout), 32'(m[16]));
`ifdef KS_FLAGS_EN
                chk("out_zero", 32'(out_zero), 32'(m[17]));
                chk("out_ovf", 32'(out_ovf), 32'(m[18]));
`else
                chk("out_zero", 32'(out_zero), 32'd0);
                chk("out_ovf", 32'(out_ovf), 32'd0);
`endif
            end
            if (out_valid && out_ready) begin
                if (q.size() > 0) void'(q.pop_front());
                exp_cnt++;
            end
            if (in_valid && in_ready) begin
                q.push_back('{a: ta, b: tb_b, cin: tcin, t: ncyc});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(logic [15:0] a, logic [15:0] b, logic cin);
        logic acc;
        int   n;
        ta       = a;
        tb_b     = b;
        tcin     = cin;
        in_valid = 1'b1;
        n        = 0;
        acc      = 1'b0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            n++;
        end
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_one(logic [15:0] a, logic [15:0] b, logic cin,
                           logic [15:0] es, logic ec, logic ez, logic eo);
        int n;
        out_ready = 1'b1;
        send(a, b, cin);
        in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("dir_seen", 32'(out_valid), 32'd1);
        chk("dir_sum", 32'(out_sum), 32'(es));
        chk("dir_cout", 32'(out_cout), 32'(ec));
`ifdef KS_FLAGS_EN
        chk("dir_zero", 32'(out_zero), 32'(ez));
        chk("dir_ovf", 32'(out_ovf), 32'(eo));
`else
        chk("dir_zero", 32'(out_zero), 32'(ez & 1'b0));
        chk("dir_ovf", 32'(out_ovf), 32'(eo & 1'b0));
`endif
        tick();
    endtask

    initial begin
        logic [15:0] hold;
        int          c0;

        chk("model_pin", 32'(model(16'h1234, 16'h1111, 1'b1)), 32'h02346);
        chk("model_ovf", 32'(model(16'h7FFF, 16'h0001, 1'b0)), 32'h48000);

        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(out_sum), 32'd0);
        chk("rst_cout", 32'(out_cout), 32'd0);
        chk("rst_zero", 32'(out_zero), 32'd0);
        chk("rst_ovf", 32'(out_ovf), 32'd0);
        chk("rst_count", 32'(out_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        tick();

        run_one(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        run_one(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        run_one(16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1);

        // Ten back-to-back beats.
        c0 = exp_cnt;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(16'($urandom), 16'($urandom), 1'($urandom));
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("b2b_count", 32'(out_count), 32'(c0 + 10));

        // Stall with a full pipe, then release.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ta   = 16'($urandom);
            tb_b = 16'($urandom);
            tick();
        end
        @(negedge clk);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_depth", 32'(q.size()), 32'd2);
        hold = out_sum;
        tick();
        tick();
        @(negedge clk);
        chk("stall_hold", 32'(out_sum), 32'(hold));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) tick();
        chk("stall_drain", 32'(q.size()), 32'd0);

        // Reset with two entries in flight.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_count", 32'(out_count), 32'd0);
        tick();
        run_one(16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            ta        = 16'($urandom);
            tb_b      = 16'($urandom);
            tcin      = 1'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                ta   = 16'hFFFF - tb_b;
                tcin = 1'b1;
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("final_drain", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
                 n_bad);
        $finish;
    end

endmodule
